ena_pulse_sequencer: RTL



---
 rtl/ena_pulse_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ena_pulse_sequencer.sv
// Avalon-MM enable-line pulse sequencer: programmable ON/OFF pulse trains on ena_out.
// Define ENA_SEQ_IRQ_EN to add the irq output and the CTRL.IRQ_EN bit.
module ena_pulse_sequencer #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ena_out,
    output logic        busy
`ifdef ENA_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [NUM_W-1:0] NUM_ONE = 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] on_time_q, on_time_d;
    logic [CNT_W-1:0] off_time_q, off_time_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_W-1:0] pulse_count_q, pulse_count_d;
    logic [NUM_W-1:0] remaining_q, remaining_d;
    logic             cont_q, cont_d;
    logic             done_q, done_d;
    logic             ena_q, ena_d;
    logic             irq_en_q;
`ifdef ENA_SEQ_IRQ_EN
    logic             irq_en_d;
`else
    assign irq_en_q = 1'b0;
`endif

    logic wr, wr_ctrl, start_req, stop_req, cont_eff;
    logic unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr && (address == 3'd0);
    assign start_req = wr_ctrl & writedata[0];
    assign stop_req  = wr_ctrl & writedata[1];
    // A START write also carries the CONT bit, so the start decision uses that value.
    assign cont_eff  = wr_ctrl ? writedata[2] : cont_q;
    assign unused_wdata = ^writedata[31:CNT_W];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        remaining_d   = remaining_q;
        done_d        = done_q;
        on_time_d     = on_time_q;
        off_time_d    = off_time_q;
        pulse_count_d = pulse_count_q;
        cont_d        = cont_q;
`ifdef ENA_SEQ_IRQ_EN
        irq_en_d      = irq_en_q;
`endif

        if (wr) begin
            case (address)
                3'd0: begin
                    cont_d = writedata[2];
`ifdef ENA_SEQ_IRQ_EN
                    irq_en_d = writedata[4];
`endif
                end
                3'd1:    done_d        = 1'b0;
                3'd2:    on_time_d     = writedata[CNT_W-1:0];
                3'd3:    off_time_d    = writedata[CNT_W-1:0];
                3'd4:    pulse_count_d = writedata[NUM_W-1:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start_req && !stop_req && (on_time_q != '0) &&
                    ((pulse_count_q != '0) || cont_eff)) begin
                    state_d     = ON;
                    cnt_d       = on_time_q - CNT_ONE;
                    remaining_d = pulse_count_q;
                end
            end
            ON: begin
                if (cnt_q == '0) begin
                    if (!cont_q) remaining_d = remaining_q - NUM_ONE;
                    if (!cont_q && (remaining_q == NUM_ONE)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (off_time_q == '0) begin
                        cnt_d = on_time_q - CNT_ONE;
                    end else begin
                        state_d = OFF;
                        cnt_d   = off_time_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            OFF: begin
                if (cnt_q == '0) begin
                    state_d = ON;
                    cnt_d   = on_time_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // STOP aborts without touching REMAINING or DONE, even on a final-pulse edge.
        if (stop_req && (state_q != IDLE)) begin
            state_d     = IDLE;
            cnt_d       = cnt_q;
            remaining_d = remaining_q;
            done_d      = done_q;
        end

        ena_d = (state_d == ON);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            remaining_q   <= '0;
            done_q        <= 1'b0;
            on_time_q     <= '0;
            off_time_q    <= '0;
            pulse_count_q <= '0;
            cont_q        <= 1'b0;
            ena_q         <= 1'b0;
`ifdef ENA_SEQ_IRQ_EN
            irq_en_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            remaining_q   <= remaining_d;
            done_q        <= done_d;
            on_time_q     <= on_time_d;
            off_time_q    <= off_time_d;
            pulse_count_q <= pulse_count_d;
            cont_q        <= cont_d;
            ena_q         <= ena_d;
`ifdef ENA_SEQ_IRQ_EN
            irq_en_q      <= irq_en_d;
`endif
        end
    end

    assign ena_out = ena_q;
    assign busy    = (state_q != IDLE);
`ifdef ENA_SEQ_IRQ_EN
    assign irq     = done_q & irq_en_q;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: begin
                readdata[2] = cont_q;
                readdata[4] = irq_en_q;
            end
            3'd1: begin
                readdata[0] = busy;
                readdata[1] = done_q;
            end
            3'd2:    readdata = 32'(on_time_q);
            3'd3:    readdata = 32'(off_time_q);
            3'd4:    readdata = 32'(pulse_count_q);
            3'd5:    readdata = 32'(remaining_q);
            default: readdata = '0;
        endcase
    end

endmodule
